// File: rtl/parking_gate_ctrl_if.sv
// rtl/parking_gate_ctrl_if.sv - sensor, code and status bundle for the car-park gate controller
interface parking_gate_ctrl_if #(
    parameter int PW_W  = 2,
    parameter int CNT_W = 4
);
    logic             sensor_entrance;
    logic             sensor_exit;
    logic             car_leave;
    logic             pw_valid;
    logic [PW_W-1:0]  password_1;
    logic [PW_W-1:0]  password_2;
    logic             GREEN_LED;
    logic             RED_LED;
    logic             gate_open;
    logic             lockout;
    logic             full;
    logic [CNT_W-1:0] occupancy;
    logic [2:0]       state_o;

    modport master (
        output sensor_entrance, sensor_exit, car_leave, pw_valid, password_1, password_2,
        input  GREEN_LED, RED_LED, gate_open, lockout, full, occupancy, state_o
    );

    modport slave (
        input  sensor_entrance, sensor_exit, car_leave, pw_valid, password_1, password_2,
        output GREEN_LED, RED_LED, gate_open, lockout, full, occupancy, state_o
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - single-gate car-park controller with code check, retry lockout and occupancy
module parking_gate_ctrl #(
    parameter int PW_W        = 2,
    parameter int PASS_1      = 1,
    parameter int PASS_2      = 2,
    parameter int CAPACITY    = 8,
    parameter int MAX_TRIES   = 3,
    parameter int WAIT_CYCLES = 64,
    parameter int LOCK_CYCLES = 128,
    localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_gate_ctrl_if.slave   bus
);
    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PASS  = 3'd1,
        WRONG_PASS = 3'd2,
        GRANT      = 3'd3,
        PASSED     = 3'd4,
        LOCKED     = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [TRY_W-1:0]   tries, tries_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [CNT_W-1:0]   occ, occ_n;
    logic               full_q, full_n;
    logic               green_q, green_n;
    logic               red_q, red_n;
    logic               gate_q, gate_n;
    logic               lock_q, lock_n;
    logic               code_ok;
    logic               car_in;

    assign code_ok = (bus.password_1 == PW_W'(PASS_1)) && (bus.password_2 == PW_W'(PASS_2));
    assign car_in  = (state == GRANT) && bus.sensor_exit;

    always_comb begin
        state_n = state;
        tries_n = tries;
        timer_n = timer;
        case (state)
            IDLE: begin
                if (bus.sensor_entrance && !full_q) begin
                    state_n = WAIT_PASS;
                    timer_n = '0;
                end
            end
            WAIT_PASS, WRONG_PASS: begin
                if (bus.pw_valid) begin
                    timer_n = '0;
                    if (code_ok) begin
                        state_n = GRANT;
                        tries_n = '0;
                    end else begin
                        tries_n = tries + TRY_W'(1);
                        state_n = (tries == TRY_W'(MAX_TRIES - 1)) ? LOCKED : WRONG_PASS;
                    end
                end else if (timer == TMR_W'(WAIT_CYCLES - 1)) begin
                    // timeout keeps the retry count so a driver cannot reset it by waiting
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            GRANT: begin
                if (bus.sensor_exit) state_n = PASSED;
            end
            PASSED: begin
                if (!bus.sensor_exit) state_n = IDLE;
            end
            LOCKED: begin
                if (timer == TMR_W'(LOCK_CYCLES - 1)) begin
                    state_n = IDLE;
                    tries_n = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tries_n = '0;
                timer_n = '0;
            end
        endcase
    end

    always_comb begin
        occ_n = occ;
        if (car_in && !bus.car_leave && occ != CNT_W'(CAPACITY))
            occ_n = occ + CNT_W'(1);
        else if (!car_in && bus.car_leave && occ != '0)
            occ_n = occ - CNT_W'(1);
        full_n = (occ_n == CNT_W'(CAPACITY));
    end

    // outputs are registered from the next state so they line up with state_o
    always_comb begin
        green_n = (state_n == GRANT) || (state_n == PASSED);
        gate_n  = (state_n == GRANT);
        lock_n  = (state_n == LOCKED);
        red_n   = (state_n == WAIT_PASS) || (state_n == WRONG_PASS) || (state_n == LOCKED) ||
                  ((state == IDLE) && (state_n == IDLE) && bus.sensor_entrance && full_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tries   <= '0;
            timer   <= '0;
            occ     <= '0;
            full_q  <= 1'b0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            gate_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state   <= state_n;
            tries   <= tries_n;
            timer   <= timer_n;
            occ     <= occ_n;
            full_q  <= full_n;
            green_q <= green_n;
            red_q   <= red_n;
            gate_q  <= gate_n;
            lock_q  <= lock_n;
        end
    end

    assign bus.GREEN_LED = green_q;
    assign bus.RED_LED   = red_q;
    assign bus.gate_open = gate_q;
    assign bus.lockout   = lock_q;
    assign bus.full      = full_q;
    assign bus.occupancy = occ;
    assign bus.state_o   = state;
endmodule
